// File: rtl/mutex_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mutex_rr_arbiter
//  Description : Clocked N-way round-robin arbiter that gives one exclusive
//                resource to one requester at a time using a four-phase
//                req/gnt handshake.  A hold-time watchdog pulses timeout_o
//                once per grant when the holder keeps the resource for
//                LOCK_TIMEOUT cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module mutex_rr_arbiter #(
    parameter int N_REQ        = 4,
    parameter int CNT_W        = 16,
    parameter int LOCK_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [$clog2(N_REQ)-1:0] gnt_id_o,
    output logic                     busy_o,
    output logic                     timeout_o
);

    localparam int ID_W = $clog2(N_REQ);

    // The watchdog is off when LOCK_TIMEOUT is zero or cannot be reached by
    // a CNT_W-bit counter.
    localparam bit              c_timeout_en  = (LOCK_TIMEOUT > 0) &&
                                                ($clog2(LOCK_TIMEOUT + 1) <= CNT_W);
    localparam logic [CNT_W-1:0] c_timeout_val = CNT_W'(LOCK_TIMEOUT);
    localparam logic [ID_W-1:0]  c_last_id     = ID_W'(N_REQ - 1);
    localparam logic [ID_W:0]    c_n_req_ext   = (ID_W+1)'(N_REQ);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e             state_q,   state_d;
    logic [ID_W-1:0]    ptr_q,     ptr_d;
    logic [ID_W-1:0]    gnt_id_q,  gnt_id_d;
    logic [N_REQ-1:0]   gnt_q,     gnt_d;
    logic               busy_q,    busy_d;
    logic               timeout_q, timeout_d;
    logic               fired_q,   fired_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;

    logic [2*N_REQ-1:0] w_req_dbl;
    logic [N_REQ-1:0]   w_req_rot;
    logic               w_found;
    logic [ID_W-1:0]    w_sel;
    logic [ID_W-1:0]    w_ptr_next;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_holder_req;

    // Rotate the request vector so bit 0 is the requester at the pointer;
    // the first set bit of the rotated vector is the round-robin winner.
    always_comb begin
        logic [ID_W:0] sum;
        w_req_dbl = {req_i, req_i} >> ptr_q;
        w_req_rot = w_req_dbl[N_REQ-1:0];
        w_found   = 1'b0;
        w_sel     = '0;
        sum       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && w_req_rot[i]) begin
                w_found = 1'b1;
                sum     = {1'b0, ptr_q} + (ID_W+1)'(i);
                if (sum >= c_n_req_ext) begin
                    sum = sum - c_n_req_ext;
                end
                w_sel = sum[ID_W-1:0];
            end
        end
    end

    // Helper values: pointer after the current holder, saturating count,
    // and whether the holder still asserts its request.
    always_comb begin
        w_ptr_next   = (gnt_id_q == c_last_id) ? '0 : gnt_id_q + ID_W'(1);
        w_cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        w_holder_req = |(req_i & gnt_q);
    end

    // Next-state and next-output logic of the IDLE/GRANT/RELEASE machine.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_id_d  = gnt_id_q;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        fired_d   = fired_q;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    gnt_d    = N_REQ'(1) << w_sel;
                    gnt_id_d = w_sel;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    fired_d  = 1'b0;
                    state_d  = ST_GRANT;
                end
            end

            ST_GRANT: begin
                // Only the holder's request matters; others cannot preempt.
                if (!w_holder_req) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = w_ptr_next;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = w_cnt_inc;
                    if (c_timeout_en && !fired_q && (w_cnt_inc == c_timeout_val)) begin
                        timeout_d = 1'b1;
                        fired_d   = 1'b1;
                    end
                end
            end

            ST_RELEASE: begin
                // Forced gap so gnt is zero for at least one cycle between grants.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears the grant without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gnt_id_q  <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            fired_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_id_q  <= gnt_id_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            fired_q   <= fired_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_id_o  = gnt_id_q;
    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;

`ifndef SYNTHESIS
    // Mutual exclusion and grant/busy consistency.
    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    a_busy:   assert property (@(posedge clk) disable iff (!rst_n) (gnt_q != '0) |-> busy_q);
`endif

endmodule
`default_nettype wire
